// File: rtl/prim_arbiter_ppc_pick.sv
// Parallel-prefix pick: prefix-OR from bit 0 upward, then isolate the lowest set bit
// as a one-hot vector and its binary index.
module prim_arbiter_ppc_pick #(
    parameter int N    = 8,
    parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    vec_i,
    output logic [N-1:0]    ppc_o,
    output logic [N-1:0]    onehot_o,
    output logic [IdxW-1:0] idx_o
);

    logic [N-1:0]    ppc;
    logic [N-1:0]    onehot;
    logic [IdxW-1:0] idx;
    logic            acc;

    always_comb begin
        ppc    = '0;
        onehot = '0;
        idx    = '0;
        acc    = 1'b0;
        for (int i = 0; i < N; i++) begin
            acc    = acc | vec_i[i];
            ppc[i] = acc;
        end
        // The lowest set bit is the only position where the prefix-OR turns on.
        onehot = ppc & ~(ppc << 1);
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx = IdxW'(i);
            end
        end
    end

    assign ppc_o    = ppc;
    assign onehot_o = onehot;
    assign idx_o    = idx;

endmodule

// File: rtl/prim_arbiter_wrr.sv
// Weighted round-robin arbiter: the owner holds priority for max(weight,1) accepted
// grants, then priority rotates past it; grant and outputs are combinational.
module prim_arbiter_wrr #(
    parameter int  N          = 8,
    parameter int  DW         = 32,
    parameter int  WeightW    = 4,
    parameter bit  EnDataPort = 1'b1,
    localparam int IdxW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         req_i,
    input  logic [N*DW-1:0]      data_i,
    input  logic [N*WeightW-1:0] weight_i,
    input  logic                 ready_i,
    output logic [N-1:0]         gnt_o,
    output logic [IdxW-1:0]      idx_o,
    output logic                 valid_o,
    output logic [DW-1:0]        data_o
);

    logic               valid;
    logic [N-1:0]       win_oh;
    logic [IdxW-1:0]    win_idx;
    logic [DW-1:0]      data_arr   [N];
    logic [WeightW-1:0] weight_arr [N];
    logic [DW-1:0]      data_sel;

    assign valid = |req_i;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign data_arr[gi]   = data_i[gi*DW +: DW];
        assign weight_arr[gi] = weight_i[gi*WeightW +: WeightW];
    end

    if (N == 1) begin : g_single
        assign win_oh  = req_i;
        assign win_idx = '0;
    end else begin : g_multi
        logic [N-1:0]       mask_q, mask_d;
        logic [IdxW-1:0]    cur_q, cur_d;
        logic [WeightW-1:0] credit_q, credit_d;
        logic               own_q, own_d;

        logic [N-1:0]       cur_oh;
        logic [N-1:0]       masked;
        logic [N-1:0]       arb_vec;
        logic [N-1:0]       ppc;
        logic [N-1:0]       pick_oh;
        logic [IdxW-1:0]    pick_idx;
        logic               req_cur;
        logic               sticky;
        logic [WeightW-1:0] w_sel;
        logic [WeightW-1:0] w_eff;

        always_comb begin
            cur_oh = '0;
            for (int i = 0; i < N; i++) begin
                cur_oh[i] = (cur_q == IdxW'(i));
            end
        end

        assign req_cur = |(req_i & cur_oh);
        assign sticky  = own_q & req_cur & (credit_q != '0);
        assign masked  = mask_q & req_i;
        assign arb_vec = (|masked) ? masked : req_i;

        prim_arbiter_ppc_pick #(
            .N    (N),
            .IdxW (IdxW)
        ) u_pick (
            .vec_i    (arb_vec),
            .ppc_o    (ppc),
            .onehot_o (pick_oh),
            .idx_o    (pick_idx)
        );

        assign win_oh  = sticky ? cur_oh : pick_oh;
        assign win_idx = sticky ? cur_q : pick_idx;

        // Weight is looked up for the fresh pick only; it matters solely at a non-sticky accept.
        always_comb begin
            w_sel = '0;
            for (int i = 0; i < N; i++) begin
                if (pick_oh[i]) begin
                    w_sel = weight_arr[i];
                end
            end
        end

        assign w_eff = (w_sel == '0) ? WeightW'(1) : w_sel;

        always_comb begin
            mask_d   = mask_q;
            cur_d    = cur_q;
            credit_d = credit_q;
            own_d    = own_q & req_cur;
            if (valid && ready_i) begin
                if (sticky) begin
                    credit_d = credit_q - WeightW'(1);
                end else begin
                    cur_d    = pick_idx;
                    own_d    = 1'b1;
                    credit_d = w_eff - WeightW'(1);
                    mask_d   = ppc & ~pick_oh;
                end
            end else if (valid && !sticky) begin
                // Stalled fresh pick: keep the winner inside the mask so it is not withdrawn.
                mask_d = ppc;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                mask_q   <= '0;
                cur_q    <= '0;
                credit_q <= '0;
                own_q    <= 1'b0;
            end else begin
                mask_q   <= mask_d;
                cur_q    <= cur_d;
                credit_q <= credit_d;
                own_q    <= own_d;
            end
        end
    end

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (win_oh[i]) begin
                data_sel = data_arr[i];
            end
        end
    end

    assign valid_o = valid;
    assign gnt_o   = (valid && ready_i) ? win_oh : '0;
    assign idx_o   = valid ? win_idx : '0;

    if (EnDataPort) begin : g_data
        assign data_o = data_sel;
    end else begin : g_no_data
        assign data_o = '1;
    end

endmodule

// File: tb/tb_prim_arbiter_wrr.sv
// Bench for prim_arbiter_wrr (N=4, DW=8, WeightW=4): vector table with scoreboard,
// hand-written async-reset sequence and a randomized property phase.
module tb_prim_arbiter_wrr;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int WW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic [N*WW-1:0] weight;
    logic            ready;
    logic [N-1:0]    gnt;
    logic [IW-1:0]   idx;
    logic            valid;
    logic [DW-1:0]   dout;

    always #5 clk = ~clk;

    prim_arbiter_wrr #(
        .N          (N),
        .DW         (DW),
        .WeightW    (WW),
        .EnDataPort (1'b1)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .req_i    (req),
        .data_i   (data),
        .weight_i (weight),
        .ready_i  (ready),
        .gnt_o    (gnt),
        .idx_o    (idx),
        .valid_o  (valid),
        .data_o   (dout)
    );

    typedef struct {
        bit          rst;
        logic [3:0]  rq;
        logic        rd;
        logic [15:0] w;
        logic [1:0]  ix;
    } vec_t;

    typedef struct {
        logic       valid;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   waitc [N];

    function automatic void add(bit r, logic [3:0] rq, logic rd, logic [15:0] w, logic [1:0] ix);
        vec_t v;
        v = '{r, rq, rd, w, ix};
        vecs.push_back(v);
    endfunction

    function automatic exp_t mk_exp(logic [3:0] rq, logic rd, logic [1:0] ix);
        exp_t e;
        logic [3:0] one;
        one     = 4'b0001;
        e.valid = |rq;
        e.idx   = e.valid ? ix : 2'd0;
        e.gnt   = (e.valid && rd) ? (one << ix) : 4'b0000;
        e.data  = e.valid ? (8'hA0 + 8'(ix)) : 8'h00;
        return e;
    endfunction

    task automatic drive(input logic [3:0] rq, input logic rd, input logic [1:0] ix);
        req   = rq;
        ready = rd;
        sb.push_back(mk_exp(rq, rd, ix));
    endtask

    task automatic check(input string name);
        exp_t e;
        #1;
        n_vec++;
        if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL %s: scoreboard empty, got gnt=%b idx=%0d", name, gnt, idx);
        end else begin
            e = sb.pop_front();
            if (valid !== e.valid || gnt !== e.gnt || idx !== e.idx || dout !== e.data) begin
                n_miss++;
                $display("FAIL %s: got valid=%b gnt=%b idx=%0d data=%h, want valid=%b gnt=%b idx=%0d data=%h",
                         name, valid, gnt, idx, dout, e.valid, e.gnt, e.idx, e.data);
            end else begin
                $display("%s: req=%b ready=%b gnt=%b idx=%0d data=%h ok", name, req, ready, gnt, idx, dout);
            end
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req    = '0;
        ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic prop(input string name, input bit ok, input int act, input int req_v);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req_v);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq_a [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [1:0] seq_b [9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};

        data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        weight = '0;
        rst_ni = 1'b0;
        req    = '0;
        ready  = 1'b0;

        // Reset state with no requests
        add(1, 4'b0000, 1, 16'h1111, 0);
        // Equal weights: plain rotation with wrap-around
        foreach (seq_a[i]) add(i == 0, 4'b1111, 1, 16'h1111, seq_a[i]);
        // w0=3: requestor 0 holds three grants per turn
        foreach (seq_b[i]) add(i == 0, 4'b1111, 1, 16'h1113, seq_b[i]);
        // Stall five cycles, winner stays 0; w0=2 shows the credit was not consumed
        for (int i = 0; i < 5; i++) add(i == 0, 4'b1111, 0, 16'h1112, 0);
        add(0, 4'b1111, 1, 16'h1112, 0);
        add(0, 4'b1111, 1, 16'h1112, 0);
        add(0, 4'b1111, 1, 16'h1112, 1);
        // No requests: outputs idle
        add(0, 4'b0000, 1, 16'h1112, 0);
        // Stalled fresh pick is latched into the mask and kept until accepted
        add(1, 4'b1111, 1, 16'h1111, 0);
        add(0, 4'b1101, 0, 16'h1111, 2);
        add(0, 4'b1111, 0, 16'h1111, 2);
        add(0, 4'b1111, 1, 16'h1111, 2);
        add(0, 4'b1111, 1, 16'h1111, 3);
        // w2=4: owner 2 drops after two grants, then returns for a fresh full turn
        add(1, 4'b0100, 1, 16'h1411, 2);
        add(0, 4'b0100, 1, 16'h1411, 2);
        add(0, 4'b1000, 1, 16'h1411, 3);
        for (int i = 0; i < 4; i++) add(0, 4'b1100, 1, 16'h1411, 2);
        add(0, 4'b1100, 1, 16'h1411, 3);
        // Weight 0 everywhere behaves as weight 1
        for (int i = 0; i < 5; i++) add(i == 0, 4'b1111, 1, 16'h0000, 2'(i));
        // w1=3: leave owner 1 mid-burst before the reset sequence below
        add(1, 4'b1111, 1, 16'h1131, 0);
        add(0, 4'b1111, 1, 16'h1131, 1);
        add(0, 4'b1111, 1, 16'h1131, 1);

        foreach (vecs[k]) begin
            @(negedge clk);
            if (vecs[k].rst) do_reset();
            weight = vecs[k].w;
            drive(vecs[k].rq, vecs[k].rd, vecs[k].ix);
            check($sformatf("vec%0d", k));
        end

        // Asynchronous reset mid-burst of owner 1
        @(negedge clk);
        #2 rst_ni = 1'b0;
        drive(4'b1111, 1, 0);
        check("rst_hold");
        @(negedge clk);
        rst_ni = 1'b1;
        drive(4'b1111, 1, 0);
        check("rst_release");
        @(negedge clk);
        drive(4'b1111, 1, 1);
        check("post_rst");

        // Randomized properties with all weights 0
        @(negedge clk);
        weight = '0;
        do_reset();
        for (int k = 0; k < N; k++) waitc[k] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req   = 4'($urandom_range(0, 15));
            ready = ($urandom_range(0, 3) != 0);
            #1;
            prop("onehot", $onehot0(gnt), int'(gnt), 1);
            prop("gnt_implies_req", (gnt & ~req) == 4'b0000, int'(gnt), int'(req));
            prop("gnt_when_accept", (gnt != 4'b0000) == ((|req) && ready), int'(gnt), int'((|req) && ready));
            for (int k = 0; k < N; k++) begin
                if (!req[k] || gnt[k]) waitc[k] = 0;
                else if (gnt != 4'b0000) waitc[k]++;
                prop($sformatf("starve%0d", k), waitc[k] <= 4, waitc[k], 4);
            end
            $display("rand%0d: req=%b ready=%b gnt=%b idx=%0d", c, req, ready, gnt, idx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
